// File: rtl/vslc_sevenseg_scan.sv
// vslc_sevenseg_scan: dual-digit 7-segment scanner for the VSLC uo_out byte.
// High nibble is shown on digit 1, low nibble on digit 0. Each digit gets a
// slot of SCAN_DIV cycles. Both enables are held off for the first
// DEAD_CYCLES of every slot so the previous digit's pattern cannot ghost.
// A shadow register is copied to the display register only on the frame
// boundary (the wrap from digit 1 to digit 0), so a frame never shows a
// mix of old and new digits.
// Optional feature: define VSLC_7SEG_DIM_EN to add a 4-bit free-running PWM
// that gates the active enable with duty (brightness+1)/16.
// Interface contract: load is a single-cycle strobe with no back-pressure.
// value/dp_in are captured on any edge where load=1, and the last load
// before a frame boundary wins.
module vslc_sevenseg_scan #(
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 16,
  parameter int SEG_ACT_LOW = 1,
  parameter int EN_ACT_LOW  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       load,
  input  logic [1:0] dp_in,
  input  logic       blank,
  input  logic [3:0] brightness,
  output logic [6:0] seg,
  output logic       seg_dp,
  output logic [1:0] dig_en,
  output logic       frame
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] CNT_DEAD = 16'(DEAD_CYCLES);
  localparam logic        SEG_INV  = (SEG_ACT_LOW != 0);
  localparam logic        EN_INV   = (EN_ACT_LOW != 0);

  logic [15:0] cnt;
  logic        digit;
  logic [7:0]  shadow;
  logic [1:0]  shadow_dp;
  logic [7:0]  disp;
  logic [1:0]  disp_dp;

  logic        wrap;
  logic        boundary;
  logic [3:0]  nib;
  logic        dp_cur;
  logic [6:0]  pat;
  logic        en_on;
  logic [1:0]  en_raw;

`ifdef VSLC_7SEG_DIM_EN
  logic [3:0] pwm;

  // Free-running PWM phase used to gate the active enable.
  always_ff @(posedge clk) begin
    if (!rst_n) pwm <= 4'd0;
    else        pwm <= pwm + 4'd1;
  end
`else
  // Brightness has no effect without the dimming feature.
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  // Slot end and frame boundary detection.
  always_comb begin
    wrap     = (cnt == CNT_LAST);
    boundary = wrap && digit;
  end

  // Select the current digit's nibble and decimal point, then hex-decode.
  always_comb begin
    nib    = digit ? disp[7:4] : disp[3:0];
    dp_cur = digit ? disp_dp[1] : disp_dp[0];
    pat    = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  // Enable of the active digit outside dead time, unless blanked or dimmed.
  always_comb begin
    en_on = (cnt >= CNT_DEAD) && !blank;
`ifdef VSLC_7SEG_DIM_EN
    en_on = en_on && (pwm <= brightness);
`endif
    en_raw = 2'b00;
    if (en_on) en_raw = digit ? 2'b10 : 2'b01;
  end

  // Slot counter and digit select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 16'd0;
      digit <= 1'b0;
    end else begin
      cnt <= wrap ? 16'd0 : cnt + 16'd1;
      if (wrap) digit <= ~digit;
    end
  end

  // Shadow capture on load; display reload only on the frame boundary,
  // using the shadow contents from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= 8'h00;
      shadow_dp <= 2'b00;
      disp      <= 8'h00;
      disp_dp   <= 2'b00;
    end else begin
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp_in;
      end
      if (boundary) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
      end
    end
  end

  // Registered pin drivers with polarity applied.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg    <= {7{SEG_INV}};
      seg_dp <= SEG_INV;
      dig_en <= {2{EN_INV}};
      frame  <= 1'b0;
    end else begin
      seg    <= pat ^ {7{SEG_INV}};
      seg_dp <= dp_cur ^ SEG_INV;
      dig_en <= en_raw ^ {2{EN_INV}};
      frame  <= boundary;
    end
  end

endmodule

// File: tb/tb_vslc_sevenseg_scan.sv
// Testbench for vslc_sevenseg_scan with SCAN_DIV=8, DEAD_CYCLES=2,
// active-low segments and active-high enables. The reference model works
// from elapsed cycles since reset: slot phase and digit follow from
// division, frames from the 2*SCAN_DIV period, and the displayed byte is
// the last byte loaded strictly before the most recent frame boundary.
module tb_vslc_sevenseg_scan;

  localparam int SD   = 8;
  localparam int DEAD = 2;
  localparam int SAL  = 1;
  localparam int EAL  = 0;
  localparam int W    = 11;

  logic       clk;
  logic       rst_n;
  logic [7:0] value;
  logic       load;
  logic [1:0] dp_in;
  logic       blank;
  logic [3:0] brightness;
  logic [6:0] seg;
  logic       seg_dp;
  logic [1:0] dig_en;
  logic       frame;

  vslc_sevenseg_scan #(
    .SCAN_DIV(SD), .DEAD_CYCLES(DEAD), .SEG_ACT_LOW(SAL), .EN_ACT_LOW(EAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .blank(blank), .brightness(brightness), .seg(seg), .seg_dp(seg_dp),
    .dig_en(dig_en), .frame(frame)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Scoreboard: expected pin state after each edge, {frame, dig_en, seg_dp, seg}.
  logic [W-1:0] exp_q[$];

  int         e = 0;          // edges since reset release
  logic [7:0] m_shown = 8'h00;
  logic [1:0] m_shown_dp = 2'b00;
  logic [7:0] m_last = 8'h00;
  logic [1:0] m_last_dp = 2'b00;
  int         m_phase, m_dig;
  logic [3:0] m_nib;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [1:0] m_en;
  logic       m_on, m_frame;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      e = 0;
      m_shown = 8'h00; m_shown_dp = 2'b00;
      m_last = 8'h00;  m_last_dp = 2'b00;
      exp_q.push_back({1'b0, (EAL != 0) ? 2'b11 : 2'b00, (SAL != 0),
                       (SAL != 0) ? 7'h7F : 7'h00});
    end else begin
      m_phase = e % SD;
      m_dig   = (e / SD) % 2;
      m_nib   = (m_dig == 1) ? m_shown[7:4] : m_shown[3:0];
      m_seg   = hex_tab[m_nib];
      m_dp    = m_shown_dp[m_dig];
      m_on    = (m_phase >= DEAD) && !blank;
`ifdef VSLC_7SEG_DIM_EN
      m_on    = m_on && ((e % 16) <= int'(brightness));
`endif
      m_en    = m_on ? ((m_dig == 1) ? 2'b10 : 2'b01) : 2'b00;
      m_frame = (e % (2 * SD)) == (2 * SD - 1);
      if (SAL != 0) begin
        m_seg = ~m_seg;
        m_dp  = ~m_dp;
      end
      if (EAL != 0) m_en = ~m_en;
      exp_q.push_back({m_frame, m_en, m_dp, m_seg});
      if (m_frame) begin
        m_shown    = m_last;
        m_shown_dp = m_last_dp;
      end
      if (load) begin
        m_last    = value;
        m_last_dp = dp_in;
      end
      e = e + 1;
    end
  end

  // Monitor: compare every presented pin state against the scoreboard.
  logic [W-1:0] got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {frame, dig_en, seg_dp, seg};
      checks = checks + 1;
      if (got !== want) begin
        errors = errors + 1;
        $display("FAIL pins cyc=%0d e=%0d got frame=%b en=%b dp=%b seg=%h want frame=%b en=%b dp=%b seg=%h",
                 cyc, e, got[10], got[9:8], got[7], got[6:0],
                 want[10], want[9:8], want[7], want[6:0]);
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v, input logic [1:0] dp);
    @(negedge clk);
    value = v; dp_in = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Load so that the capturing edge is exactly a frame-boundary edge.
  task automatic load_at_boundary(input logic [7:0] v, input logic [1:0] dp);
    int found;
    found = 0;
    for (int i = 0; i < 4 * SD; i++) begin
      @(negedge clk);
      if (rst_n && (e % (2 * SD)) == (2 * SD - 1)) begin
        found = 1;
        break;
      end
    end
    checks = checks + 1;
    if (found == 0) begin
      errors = errors + 1;
      $display("FAIL boundary_wait got none within %0d cycles want one", 4 * SD);
    end else begin
      value = v; dp_in = dp; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  // Stimulus
  initial begin
    rst_n = 1'b0; load = 1'b0; value = 8'h00; dp_in = 2'b00;
    blank = 1'b0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    do_load(8'hA5, 2'b01);
    idle(3 * 2 * SD);

    do_load(8'h12, 2'b00);
    idle(3);
    do_load(8'h34, 2'b10);
    idle(2 * 2 * SD + 5);

    load_at_boundary(8'h56, 2'b11);
    idle(3 * 2 * SD);

    idle(5);
    @(negedge clk) blank = 1'b1;
    idle(7);
    blank = 1'b0;
    idle(2 * 2 * SD);

    do_load(8'hFF, 2'b11);
    idle(2);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(3 * 2 * SD);

    brightness = 4'd3;
    idle(4 * 2 * SD);
    brightness = 4'd15;
    idle(SD);

    repeat (500) begin
      @(negedge clk);
      load       = ($urandom_range(0, 9) == 0);
      value      = 8'($urandom);
      dp_in      = 2'($urandom);
      blank      = ($urandom_range(0, 15) == 0);
      brightness = 4'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    load = 1'b0; blank = 1'b0; rst_n = 1'b1;
    idle(2 * 2 * SD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
